aes_top: RTL and testbench

//  AES-128 encryption core (FIPS-197), iterative datapath: one round per AES_clk with on-the-fly key expansion.

---
 rtl/aes_pkg.sv | 91 +++++++++
 rtl/aes_sbox.sv | 11 +
 rtl/aes_top.sv | 106 ++++++++++
 tb/tb_aes_top.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES-128 shared constants and round helpers: S-box table, Rcon, ShiftRows, MixColumns, key step.
package aes_pkg;

   localparam int NR = 10;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } aes_state_e;

   // Entry 0 sits in the most significant byte, so SBOX[x] is the FIPS S-box value of x.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [0:10][7:0] RCON = {
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   function automatic logic [7:0] sbox_f(input logic [7:0] b);
      return SBOX[b];
   endfunction

   function automatic logic [7:0] rcon_f(input logic [3:0] r);
      return (r <= 4'd10) ? RCON[r] : 8'h00;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return b[7] ? ((b << 1) ^ 8'h1b) : (b << 1);
   endfunction

   // Byte (row r, column c) sits at index 4*c+r, MSB first.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
      end
      return o;
   endfunction

   function automatic logic [127:0] key_step(input logic [127:0] k, input logic [31:0] sub_rot,
                                             input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w0 = k[127:96] ^ sub_rot ^ {rc, 24'h000000};
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0] ^ w2;
      return {w0, w1, w2, w3};
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box lookup for a single byte.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   assign out_byte = sbox_f(in_byte);

endmodule

// File: rtl/aes_top.sv
// Iterative AES-128 encryption core: one round per clock, round key expanded on the fly.
//   state | meaning
//   IDLE  | waiting for AES_en, last ciphertext held on AES_data_out
//   RUN   | rounds 1..10 in progress, inputs and AES_en ignored
module aes_top
   import aes_pkg::*;
(
   input  logic         AES_clk,
   input  logic         AES_rst,
   input  logic         AES_en,
   input  logic [127:0] AES_data_in,
   input  logic [127:0] AES_key_in,
   output logic [127:0] AES_data_out,
   output logic         AES_data_out_valid
);

   aes_state_e   fsm_q, fsm_d;
   logic [3:0]   rnd_q, rnd_d;
   logic [127:0] state_q, state_d;
   logic [127:0] rkey_q, rkey_d;
   logic [127:0] data_out_q, data_out_d;
   logic         valid_q, valid_d;

   logic [127:0] sb_bytes;
   logic [31:0]  rot_word;
   logic [31:0]  sub_rot;
   logic [127:0] rk_next;
   logic [127:0] sr_bytes;
   logic [127:0] round_out;
   logic         last_round;

   for (genvar gi = 0; gi < 16; gi++) begin : g_sb_data
      aes_sbox u_sbox (
         .in_byte  (state_q[127-8*gi -: 8]),
         .out_byte (sb_bytes[127-8*gi -: 8])
      );
   end

   assign rot_word = {rkey_q[23:0], rkey_q[31:24]};

   for (genvar gk = 0; gk < 4; gk++) begin : g_sb_key
      aes_sbox u_sbox (
         .in_byte  (rot_word[31-8*gk -: 8]),
         .out_byte (sub_rot[31-8*gk -: 8])
      );
   end

   assign last_round = (rnd_q == 4'(NR));
   assign rk_next    = key_step(rkey_q, sub_rot, rcon_f(rnd_q));
   assign sr_bytes   = shift_rows(sb_bytes);
   assign round_out  = (last_round ? sr_bytes : mix_columns(sr_bytes)) ^ rk_next;

   always_comb begin
      fsm_d      = fsm_q;
      rnd_d      = rnd_q;
      state_d    = state_q;
      rkey_d     = rkey_q;
      data_out_d = data_out_q;
      valid_d    = 1'b0;
      case (fsm_q)
         IDLE: begin
            if (AES_en) begin
               state_d = AES_data_in ^ AES_key_in;
               rkey_d  = AES_key_in;
               rnd_d   = 4'd1;
               fsm_d   = RUN;
            end
         end
         RUN: begin
            state_d = round_out;
            rkey_d  = rk_next;
            if (last_round) begin
               data_out_d = round_out;
               valid_d    = 1'b1;
               rnd_d      = 4'd0;
               fsm_d      = IDLE;
            end else begin
               rnd_d = rnd_q + 4'd1;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge AES_clk or posedge AES_rst) begin
      if (AES_rst) begin
         fsm_q      <= IDLE;
         rnd_q      <= 4'd0;
         state_q    <= '0;
         rkey_q     <= '0;
         data_out_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         fsm_q      <= fsm_d;
         rnd_q      <= rnd_d;
         state_q    <= state_d;
         rkey_q     <= rkey_d;
         data_out_q <= data_out_d;
         valid_q    <= valid_d;
      end
   end

   assign AES_data_out       = data_out_q;
   assign AES_data_out_valid = valid_q;

endmodule

// File: tb/tb_aes_top.sv
// Self-checking bench for aes_top: known-answer vectors plus random vectors against a byte-level AES model.
module tb_aes_top;

   logic         AES_clk = 1'b0;
   logic         AES_rst;
   logic         AES_en;
   logic [127:0] AES_data_in;
   logic [127:0] AES_key_in;
   logic [127:0] AES_data_out;
   logic         AES_data_out_valid;

   int checks   = 0;
   int failures = 0;

   logic [7:0] sbox_t [256];

   aes_top dut (
      .AES_clk            (AES_clk),
      .AES_rst            (AES_rst),
      .AES_en             (AES_en),
      .AES_data_in        (AES_data_in),
      .AES_key_in         (AES_key_in),
      .AES_data_out       (AES_data_out),
      .AES_data_out_valid (AES_data_out_valid)
   );

   always #5 AES_clk = ~AES_clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = '0;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [7:0] r;
      r = (v << n) | (v >> (8 - n));
      return r;
   endfunction

   // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++) begin
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         end
         sbox_t[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] ref_aes(input logic [127:0] pt, input logic [127:0] key);
      logic [7:0]   st  [16];
      logic [7:0]   tmp [16];
      logic [31:0]  w   [44];
      logic [31:0]  t;
      logic [7:0]   rc;
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
            t = t ^ {rc, 24'h000000};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) st[i] = sbox_t[st[i]];
         for (int i = 0; i < 16; i++) tmp[i] = st[(i%4) + 4*(((i/4) + (i%4)) % 4)];
         for (int i = 0; i < 16; i++) st[i] = tmp[i];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
               st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         end
         for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
      end
      res = '0;
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
      return res;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(posedge AES_clk);
         #1;
         n++;
      end while (!AES_data_out_valid && n < 20);
   endtask

   // One operation: sample at E0, scramble inputs during the run, expect valid 10 clocks later.
   task automatic run_op(input string tag, input logic [127:0] pt, input logic [127:0] key,
                         input logic [127:0] exp);
      int n;
      @(negedge AES_clk);
      AES_en      = 1'b1;
      AES_data_in = pt;
      AES_key_in  = key;
      @(posedge AES_clk);
      #1;
      AES_en      = 1'b0;
      AES_data_in = rand128();
      AES_key_in  = rand128();
      wait_valid(n);
      chk($sformatf("%s_latency", tag), 128'(n), 128'd10);
      chk($sformatf("%s_out", tag), AES_data_out, exp);
      @(posedge AES_clk);
      #1;
      chk($sformatf("%s_valid_clear", tag), 128'(AES_data_out_valid), 128'd0);
      chk($sformatf("%s_out_hold", tag), AES_data_out, exp);
   endtask

   initial begin
      logic [127:0] pt, key, exp, last;
      int pulses;

      AES_rst     = 1'b1;
      AES_en      = 1'b0;
      AES_data_in = '0;
      AES_key_in  = '0;
      build_sbox();

      repeat (2) @(posedge AES_clk);
      #1;
      chk("reset_out", AES_data_out, 128'd0);
      chk("reset_valid", 128'(AES_data_out_valid), 128'd0);
      @(negedge AES_clk);
      AES_rst = 1'b0;

      repeat (3) @(posedge AES_clk);
      #1;
      chk("idle_no_en_valid", 128'(AES_data_out_valid), 128'd0);
      chk("idle_no_en_out", AES_data_out, 128'd0);

      run_op("fips_c1", 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
             128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      run_op("fips_b", 128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
             128'h3925841d02dc09fbdc118597196a0b32);
      run_op("all_zero", 128'd0, 128'd0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);

      for (int k = 0; k < 5; k++) begin
         pt  = rand128();
         key = rand128();
         run_op($sformatf("rand%0d", k), pt, key, ref_aes(pt, key));
      end

      // AES_en held high: a new operation every 11 clocks; data_in is junk except at each sampling edge.
      pt  = rand128();
      key = rand128();
      exp = ref_aes(pt, key);
      @(negedge AES_clk);
      AES_en      = 1'b1;
      AES_data_in = pt;
      AES_key_in  = key;
      pulses      = 0;
      for (int cyc = 0; cyc < 56; cyc++) begin
         @(posedge AES_clk);
         #1;
         chk($sformatf("hold_valid_c%0d", cyc), 128'(AES_data_out_valid), 128'((cyc % 11) == 10));
         if (AES_data_out_valid) pulses++;
         if ((cyc % 11) == 10) chk($sformatf("hold_out_c%0d", cyc), AES_data_out, exp);
         AES_data_in = (((cyc + 1) % 11) == 0) ? pt : rand128();
         AES_en      = (cyc < 50);
      end
      chk("hold_pulse_count", 128'(pulses), 128'd5);

      // Idle with inputs toggling: output must hold and no pulse may appear.
      last = exp;
      for (int cyc = 0; cyc < 15; cyc++) begin
         @(negedge AES_clk);
         AES_data_in = rand128();
         AES_key_in  = rand128();
         @(posedge AES_clk);
         #1;
         chk($sformatf("idle_valid_c%0d", cyc), 128'(AES_data_out_valid), 128'd0);
         chk($sformatf("idle_out_c%0d", cyc), AES_data_out, last);
      end

      // Reset in round 5 aborts the run.
      @(negedge AES_clk);
      AES_en      = 1'b1;
      AES_data_in = rand128();
      AES_key_in  = rand128();
      @(posedge AES_clk);
      #1;
      AES_en = 1'b0;
      repeat (4) @(posedge AES_clk);
      #2;
      AES_rst = 1'b1;
      #1;
      chk("abort_out", AES_data_out, 128'd0);
      chk("abort_valid", 128'(AES_data_out_valid), 128'd0);
      repeat (2) @(posedge AES_clk);
      @(negedge AES_clk);
      AES_rst = 1'b0;
      pulses  = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(posedge AES_clk);
         #1;
         if (AES_data_out_valid) pulses++;
      end
      chk("abort_no_pulse", 128'(pulses), 128'd0);
      chk("abort_out_held", AES_data_out, 128'd0);

      pt  = rand128();
      key = rand128();
      run_op("after_abort", pt, key, ref_aes(pt, key));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
